// File: rtl/ex_fp_pipe_if.sv
// FP execute-stage bus: reservation-station candidate slots in, issue grant
// back to the RS, and the valid/ready writeback channel towards ROB/regfile.
//   slave  : the execute pipe (consumes RS slots + wb_ready, drives the rest)
//   master : the RS / writeback side
// Per-slot fields are flattened, slot i at [i*W +: W].
interface ex_fp_pipe_if #(
    parameter int NUM_RS = 2,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int AGE_W  = 4
);
    logic [NUM_RS-1:0]        rs_valid;
    logic [NUM_RS-1:0]        rs_rdy1;
    logic [NUM_RS-1:0]        rs_rdy2;
    logic [NUM_RS*DATA_W-1:0] rs_src1;
    logic [NUM_RS*DATA_W-1:0] rs_src2;
    logic [NUM_RS*5-1:0]      rs_op;
    logic [NUM_RS*5-1:0]      rs_wraddr;
    logic [NUM_RS-1:0]        rs_regwrite;
    logic [NUM_RS*TAG_W-1:0]  rs_tag;
    logic [NUM_RS*AGE_W-1:0]  rs_age;
    logic [NUM_RS-1:0]        rs_issue;
    logic                     wb_valid;
    logic                     wb_ready;
    logic [74:0]              executed_inst;
    logic [TAG_W-1:0]         fp_rob_num;
    logic [DATA_W-1:0]        writedata_fp;
    logic [4:0]               writeaddr_fp;
    logic                     writeen_fp;

    modport master (
        output rs_valid, rs_rdy1, rs_rdy2, rs_src1, rs_src2, rs_op, rs_wraddr,
               rs_regwrite, rs_tag, rs_age, wb_ready,
        input  rs_issue, wb_valid, executed_inst, fp_rob_num, writedata_fp,
               writeaddr_fp, writeen_fp
    );

    modport slave (
        input  rs_valid, rs_rdy1, rs_rdy2, rs_src1, rs_src2, rs_op, rs_wraddr,
               rs_regwrite, rs_tag, rs_age, wb_ready,
        output rs_issue, wb_valid, executed_inst, fp_rob_num, writedata_fp,
               writeaddr_fp, writeen_fp
    );
endinterface

// File: rtl/ex_fp_pipe.sv
// FP execute stage. Picks the oldest fully-ready RS slot (smallest age, ties to
// lowest index), evaluates it in a combinational single-precision core and
// carries the result through LAT register stages with valid/ready back-pressure.
// Ports:
//   i_clk   : clock
//   i_rst   : synchronous active-high reset (wins over flush)
//   i_flush : kill every in-flight op at the next edge, block issue this cycle
//   io_fp   : RS slots, issue grant and writeback channel (ex_fp_pipe_if.slave)
// FP core ops: 0 FADD, 1 FSUB, 2 FABS(a), 3 FNEG(a), others pass a through.
// The adder flushes denormal inputs to zero and truncates shifted-out bits.
module ex_fp_pipe #(
    parameter int NUM_RS = 2,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int AGE_W  = 4,
    parameter int LAT    = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    ex_fp_pipe_if.slave   io_fp
);
    localparam int SEL_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
    localparam logic [4:0] OP_FADD = 5'd0;
    localparam logic [4:0] OP_FSUB = 5'd1;
    localparam logic [4:0] OP_FABS = 5'd2;
    localparam logic [4:0] OP_FNEG = 5'd3;

    function automatic logic [31:0] fp_core(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op);
        logic        sa, sb, sl;
        logic [7:0]  el, es;
        logic [24:0] ml, ms, sum;
        logic [4:0]  p;
        logic [31:0] r;
        sa = a[31];
        sb = b[31] ^ (op == OP_FSUB);
        // Larger magnitude goes to the "l" side so subtraction never goes negative.
        if (a[30:0] >= b[30:0]) begin
            sl = sa; el = a[30:23]; es = b[30:23];
            ml = (a[30:23] == 8'd0) ? 25'd0 : {2'b01, a[22:0]};
            ms = (b[30:23] == 8'd0) ? 25'd0 : {2'b01, b[22:0]};
        end else begin
            sl = sb; el = b[30:23]; es = a[30:23];
            ml = (b[30:23] == 8'd0) ? 25'd0 : {2'b01, b[22:0]};
            ms = (a[30:23] == 8'd0) ? 25'd0 : {2'b01, a[22:0]};
        end
        ms = ((el - es) > 8'd24) ? 25'd0 : (ms >> (el - es));
        p  = 5'd0;
        if (sa == sb) begin
            sum = ml + ms;
            if (sum[24])          r = {sl, el + 8'd1, sum[23:1]};
            else if (sum == '0)   r = 32'd0;
            else                  r = {sl, el, sum[22:0]};
        end else begin
            sum = ml - ms;
            if (sum == '0) begin
                r = 32'd0;
            end else begin
                // Renormalise: bring the leading one back to bit 23.
                for (int i = 0; i < 24; i++) if (sum[i]) p = 5'(i);
                sum = sum << (5'd23 - p);
                r   = {sl, el - 8'(5'd23 - p), sum[22:0]};
            end
        end
        case (op)
            OP_FADD, OP_FSUB: fp_core = r;
            OP_FABS:          fp_core = {1'b0, a[30:0]};
            OP_FNEG:          fp_core = {~a[31], a[30:0]};
            default:          fp_core = a;
        endcase
    endfunction

    logic [NUM_RS-1:0]           w_elig;
    logic                        w_found;
    logic [SEL_W-1:0]            w_sel;
    logic [AGE_W-1:0]            w_best;
    logic                        w_issue;
    logic [DATA_W-1:0]           w_core;
    logic [LAT-1:0]              w_acc;

    logic [LAT-1:0]              r_v;
    logic [LAT-1:0][DATA_W-1:0]  r_res;
    logic [LAT-1:0][4:0]         r_wa;
    logic [LAT-1:0]              r_rw;
    logic [LAT-1:0][TAG_W-1:0]   r_tag;

    logic [LAT-1:0]              w_in_v;
    logic [LAT-1:0][DATA_W-1:0]  w_in_res;
    logic [LAT-1:0][4:0]         w_in_wa;
    logic [LAT-1:0]              w_in_rw;
    logic [LAT-1:0][TAG_W-1:0]   w_in_tag;

    assign w_elig = io_fp.rs_valid & io_fp.rs_rdy1 & io_fp.rs_rdy2;

    // Oldest eligible slot; strict '<' keeps the lowest index on equal ages.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_best  = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (w_elig[i] && (!w_found || io_fp.rs_age[i*AGE_W +: AGE_W] < w_best)) begin
                w_found = 1'b1;
                w_sel   = SEL_W'(i);
                w_best  = io_fp.rs_age[i*AGE_W +: AGE_W];
            end
        end
    end

    // Stage k can load iff some stage at or after it is empty, or the output drains;
    // this lets bubbles collapse without ever overwriting a held result.
    always_comb begin
        for (int k = 0; k < LAT; k++)
            w_acc[k] = io_fp.wb_ready | ((LAT'(~r_v) >> k) != '0);
    end

    assign w_issue = w_found & w_acc[0] & ~i_flush & ~i_rst;
    assign io_fp.rs_issue = w_issue ? (NUM_RS'(1) << w_sel) : '0;

    assign w_core = DATA_W'(fp_core(32'(io_fp.rs_src1[int'(w_sel)*DATA_W +: DATA_W]),
                                    32'(io_fp.rs_src2[int'(w_sel)*DATA_W +: DATA_W]),
                                    io_fp.rs_op[int'(w_sel)*5 +: 5]));

    // Next-stage inputs: S1 takes the granted op, Sk takes S(k-1).
    always_comb begin
        w_in_v[0]   = w_issue;
        w_in_res[0] = w_core;
        w_in_wa[0]  = io_fp.rs_wraddr[int'(w_sel)*5 +: 5];
        w_in_rw[0]  = io_fp.rs_regwrite[w_sel];
        w_in_tag[0] = io_fp.rs_tag[int'(w_sel)*TAG_W +: TAG_W];
        for (int k = 1; k < LAT; k++) begin
            w_in_v[k]   = r_v[k-1];
            w_in_res[k] = r_res[k-1];
            w_in_wa[k]  = r_wa[k-1];
            w_in_rw[k]  = r_rw[k-1];
            w_in_tag[k] = r_tag[k-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v   <= '0;
            r_res <= '0;
            r_wa  <= '0;
            r_rw  <= '0;
            r_tag <= '0;
        end else begin
            for (int k = 0; k < LAT; k++) begin
                if (w_acc[k]) begin
                    r_v[k]   <= w_in_v[k];
                    r_res[k] <= w_in_res[k];
                    r_wa[k]  <= w_in_wa[k];
                    r_rw[k]  <= w_in_rw[k];
                    r_tag[k] <= w_in_tag[k];
                end
            end
            // Only valid bits are killed; stale data is harmless behind v=0.
            if (i_flush) r_v <= '0;
        end
    end

    assign io_fp.wb_valid     = r_v[LAT-1];
    assign io_fp.writedata_fp = r_res[LAT-1];
    assign io_fp.writeaddr_fp = r_wa[LAT-1];
    assign io_fp.fp_rob_num   = r_tag[LAT-1];
    assign io_fp.writeen_fp   = r_v[LAT-1] & io_fp.wb_ready & r_rw[LAT-1];
    // Layout: [4:0] wraddr, [36:5] result, [37] 0, [38] regwrite, rest 0.
    assign io_fp.executed_inst = {36'd0, r_rw[LAT-1], 1'b0, 32'(r_res[LAT-1]), r_wa[LAT-1]};
endmodule
